// File: rtl/fx3_out_path_writer.sv
// FX3 slave-FIFO transmit path: drains one PPFIFO chunk into FX3 DMA buffers, one word per clock.
// Define FX3_OUT_ZLP_EN to close buffer-aligned and empty chunks with a zero-length packet.
`default_nettype none

module fx3_out_path_writer #(
  parameter int DATA_WIDTH    = 32,
  parameter int DMA_BUF_WORDS = 512
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  o_ready,
  input  logic                  i_enable,
  output logic                  o_busy,
  output logic                  o_finished,
  input  logic                  i_dma_buf_ready,
  output logic                  o_dma_buf_finished,
  input  logic                  i_read_ready,
  output logic                  o_read_activate,
  input  logic [23:0]           i_read_size,
  output logic                  o_read_stb,
  input  logic [DATA_WIDTH-1:0] i_read_data,
  output logic [DATA_WIDTH-1:0] o_fx3_data,
  output logic                  o_fx3_oe,
  output logic                  o_fx3_wr_n,
  output logic                  o_fx3_pkt_end_n
);

  localparam int BCW = $clog2(DMA_BUF_WORDS) + 1;
  localparam logic [BCW-1:0] BUF_FULL = BCW'(DMA_BUF_WORDS);

  typedef enum logic [2:0] {
    IDLE, CLAIM, WAIT_BUF, WRITE, BUF_DONE, DONE
  } state_t;

  state_t                state_q;
  logic [23:0]           total_q, sent_q, sent_d;
  logic [BCW-1:0]        buf_cnt_q, buf_cnt_d;
  logic                  ready_q, busy_q, finished_q, buf_fin_q, activate_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  oe_q, wr_n_q, pkt_end_n_q;
  logic                  last_word, buf_full, zlp_pending;

`ifdef FX3_OUT_ZLP_EN
  logic zlp_q;
  assign zlp_pending = zlp_q;
`else
  assign zlp_pending = 1'b0;
`endif

  always_comb begin
    sent_d    = sent_q + 24'd1;
    buf_cnt_d = buf_cnt_q + 1'b1;
  end

  assign last_word = (sent_d == total_q);
  assign buf_full  = (buf_cnt_d == BUF_FULL);

  // The FIFO is first-word-fall-through, so popping is a pure decode of WRITE.
  assign o_read_stb = (state_q == WRITE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      total_q     <= '0;
      sent_q      <= '0;
      buf_cnt_q   <= '0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      finished_q  <= 1'b0;
      buf_fin_q   <= 1'b0;
      activate_q  <= 1'b0;
      data_q      <= '0;
      oe_q        <= 1'b0;
      wr_n_q      <= 1'b1;
      pkt_end_n_q <= 1'b1;
`ifdef FX3_OUT_ZLP_EN
      zlp_q       <= 1'b0;
`endif
    end else if (!i_enable && state_q != IDLE && state_q != DONE) begin
      // Grant withdrawn mid-transfer: release everything, the PPFIFO drops the rest.
      state_q     <= IDLE;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      buf_fin_q   <= 1'b0;
      activate_q  <= 1'b0;
      oe_q        <= 1'b0;
      wr_n_q      <= 1'b1;
      pkt_end_n_q <= 1'b1;
`ifdef FX3_OUT_ZLP_EN
      zlp_q       <= 1'b0;
`endif
    end else begin
      if (buf_fin_q && !i_dma_buf_ready) begin
        buf_fin_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          ready_q <= i_read_ready;
          if (i_enable && i_read_ready) begin
            ready_q    <= 1'b0;
            activate_q <= 1'b1;
            busy_q     <= 1'b1;
            total_q    <= i_read_size;
            sent_q     <= '0;
            state_q    <= CLAIM;
`ifdef FX3_OUT_ZLP_EN
            zlp_q      <= 1'b0;
`endif
          end
        end
        CLAIM: begin
          if (total_q == '0) begin
`ifdef FX3_OUT_ZLP_EN
            zlp_q      <= 1'b1;
            state_q    <= WAIT_BUF;
`else
            activate_q <= 1'b0;
            busy_q     <= 1'b0;
            finished_q <= 1'b1;
            state_q    <= DONE;
`endif
          end else begin
            state_q <= WAIT_BUF;
          end
        end
        WAIT_BUF: begin
          if (i_dma_buf_ready && !buf_fin_q) begin
            buf_cnt_q <= '0;
            oe_q      <= 1'b1;
            state_q   <= WRITE;
`ifdef FX3_OUT_ZLP_EN
            if (zlp_q) begin
              zlp_q       <= 1'b0;
              oe_q        <= 1'b0;
              pkt_end_n_q <= 1'b0;
              state_q     <= BUF_DONE;
            end
`endif
          end
        end
        WRITE: begin
          data_q    <= i_read_data;
          wr_n_q    <= 1'b0;
          sent_q    <= sent_d;
          buf_cnt_q <= buf_cnt_d;
          // A full buffer commits on its own; only a short final buffer needs packet end.
          if (last_word) begin
            state_q <= BUF_DONE;
            if (!buf_full) begin
              pkt_end_n_q <= 1'b0;
            end
`ifdef FX3_OUT_ZLP_EN
            if (buf_full) begin
              zlp_q <= 1'b1;
            end
`endif
          end else if (buf_full) begin
            state_q <= BUF_DONE;
          end
        end
        BUF_DONE: begin
          wr_n_q      <= 1'b1;
          oe_q        <= 1'b0;
          pkt_end_n_q <= 1'b1;
          buf_fin_q   <= 1'b1;
          if (sent_q < total_q || zlp_pending) begin
            state_q <= WAIT_BUF;
          end else begin
            activate_q <= 1'b0;
            busy_q     <= 1'b0;
            finished_q <= 1'b1;
            state_q    <= DONE;
          end
        end
        DONE: begin
          if (!i_enable) begin
            finished_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_ready            = ready_q;
  assign o_busy             = busy_q;
  assign o_finished         = finished_q;
  assign o_dma_buf_finished = buf_fin_q;
  assign o_read_activate    = activate_q;
  assign o_fx3_data         = data_q;
  assign o_fx3_oe           = oe_q;
  assign o_fx3_wr_n         = wr_n_q;
  assign o_fx3_pkt_end_n    = pkt_end_n_q;

endmodule

`default_nettype wire

// File: doc/fx3_out_path_writer.md
# fx3_out_path_writer

Transmit-side data path for the FX3 slave-FIFO bus: drains one ping-pong FIFO chunk into FX3 DMA buffers, one 32-bit word per clock. Sits between the output PPFIFO and the FX3 GPIF pins. Answers the bus controller's out-path handshake: ready, enable, busy, dma-buf-ready/finished, finished. The bus controller owns socket selection; this block only drives data, strobes and packet end.

## Interface
- DATA_WIDTH, 32, FX3 bus and FIFO word width
- DMA_BUF_WORDS, 512, words per FX3 DMA buffer (2048 bytes); power of two, at least 4
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high; clock clk
- o_ready  out  1  chunk waiting in FIFO, block idle
- i_enable  in  1  controller grant; held for the whole transfer
- o_busy  out  1  transfer in progress
- o_finished  out  1  all words sent; held until i_enable falls
- i_dma_buf_ready  in  1  controller has pointed the socket at a free FX3 buffer
- o_dma_buf_finished  out  1  current buffer closed; held until i_dma_buf_ready falls
- i_read_ready  in  1  PPFIFO chunk available
- o_read_activate  out  1  PPFIFO chunk claimed
- i_read_size  in  24  chunk length in words, valid with i_read_ready
- o_read_stb  out  1  pop one word (first-word-fall-through)
- i_read_data  in  DATA_WIDTH  current FIFO head word
- o_fx3_data  out  DATA_WIDTH  FX3 data bus
- o_fx3_oe  out  1  FPGA drives data bus
- o_fx3_wr_n  out  1  FX3 write strobe, active low
- o_fx3_pkt_end_n  out  1  short-packet commit, active low

## Operation
- States: IDLE, CLAIM, WAIT_BUF, WRITE, BUF_DONE, DONE.
- IDLE: o_ready = i_read_ready, registered. On i_enable and i_read_ready: assert o_read_activate, latch i_read_size into r_total (24 bit), clear r_sent; go to CLAIM.
- CLAIM: o_busy = 1. If r_total = 0, go to DONE, or to WAIT_BUF when the ZLP feature is on. Otherwise go to WAIT_BUF.
- WAIT_BUF: on i_dma_buf_ready with o_dma_buf_finished low, clear r_buf_cnt (log2(DMA_BUF_WORDS)+1 bit) and set o_fx3_oe; go to WRITE.
- WRITE: each cycle o_read_stb = 1 (combinational decode of state), o_fx3_data <= i_read_data, o_fx3_wr_n <= 0, r_sent and r_buf_cnt increment. Exit conditions:
  - On the last chunk word: go to BUF_DONE. If r_buf_cnt+1 < DMA_BUF_WORDS, assert o_fx3_pkt_end_n low with that word.
  - On r_buf_cnt+1 = DMA_BUF_WORDS (buffer full, words remaining): go to BUF_DONE.
- BUF_DONE: o_fx3_wr_n = 1, o_fx3_oe = 0, o_dma_buf_finished = 1. When i_dma_buf_ready falls, clear it. Go to WAIT_BUF if r_sent < r_total, else DONE.
- DONE: o_read_activate = 0, o_busy = 0, o_finished = 1. When i_enable falls, go to IDLE.
- Abort: i_enable low in any state other than IDLE or DONE. Next edge forces IDLE and drops o_read_activate, o_fx3_wr_n, o_fx3_oe and o_busy. Remaining FIFO words are discarded by the PPFIFO on release.
- Reset values: o_ready 0, o_busy 0, o_finished 0, o_dma_buf_finished 0, o_read_activate 0, o_read_stb 0, o_fx3_data 0, o_fx3_oe 0, o_fx3_wr_n 1, o_fx3_pkt_end_n 1. Reset mid-transfer returns to IDLE at the next edge.

## Timing
- The FIFO head word is valid in the cycle o_read_stb is high and is captured that edge. The next word is valid the following cycle, giving one word per clock with no bubbles inside a buffer.
- FX3 pins are registered: one cycle from o_read_stb to o_fx3_wr_n low with matching data.
- o_fx3_pkt_end_n is low for exactly one cycle, coincident with the last o_fx3_wr_n low.
- Minimum gap between buffers: 2 cycles (BUF_DONE, WAIT_BUF) plus the controller's i_dma_buf_ready turnaround.
- If i_dma_buf_ready and i_enable fall on the same edge: abort has priority and o_dma_buf_finished clears.

## Configuration
- FX3_OUT_ZLP_EN defined: if a chunk ends exactly on a buffer boundary, or r_total = 0, the block sends a zero-length packet after one extra i_dma_buf_ready. The ZLP is one cycle with o_fx3_pkt_end_n low and o_fx3_wr_n high, then BUF_DONE.
- FX3_OUT_ZLP_EN undefined: boundary-aligned chunks end after the full-buffer BUF_DONE. A zero-size chunk goes CLAIM to DONE with no FX3 activity.

## Test plan
- Size 10, DMA_BUF_WORDS 512 -> 10 consecutive wr_n-low cycles with data 0..9; pkt_end_n low on word 9; one buf_finished; finished high until enable falls.
- Size 1030 -> buffers of 512, 512 and 6; buf_finished three times; pkt_end_n only on word 1029; no bubbles inside a buffer.
- Size 1024 -> two full buffers, no pkt_end_n. With FX3_OUT_ZLP_EN, a third dma_buf_ready yields one ZLP cycle: pkt_end_n 0, wr_n 1.
- Size 0 -> without the macro, finished two cycles after enable, no wr_n. With the macro, one ZLP.
- i_enable dropped after word 100 of 300 -> next edge wr_n 1, oe 0, read_activate 0, busy 0, state IDLE.
- rst asserted mid-buffer -> all outputs at reset values next edge; a new chunk then transfers correctly.
